// File: rtl/fifo_burst_packer_if.sv
// Handshake bundle between fifo_burst_packer, its upstream FIFO read port
// and the downstream consumer of packed words.
interface fifo_burst_packer_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PACK_RATIO     = 4,
    parameter int FIFO_NUM_WIDTH = 11
);
    logic [FIFO_NUM_WIDTH-1:0]        fifo_num_i;
    logic                             fifo_rd_en_o;
    logic [DATA_WIDTH-1:0]            fifo_dout_i;
    logic [DATA_WIDTH*PACK_RATIO-1:0] m_data_o;
    logic                             m_valid_o;
    logic                             m_last_o;
    logic                             m_ready_i;

    modport master (
        input  fifo_num_i, fifo_dout_i, m_ready_i,
        output fifo_rd_en_o, m_data_o, m_valid_o, m_last_o
    );

    modport slave (
        output fifo_num_i, fifo_dout_i, m_ready_i,
        input  fifo_rd_en_o, m_data_o, m_valid_o, m_last_o
    );
endinterface

// File: rtl/fifo_burst_packer.sv
// Reads whole bursts from a FIFO once enough words are present, packs
// PACK_RATIO words LSB-first per output word and streams them with last-marking.
module fifo_burst_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PACK_RATIO     = 4,
    parameter int BURST_LEN      = 16,
    parameter int FIFO_NUM_WIDTH = 11
) (
    input  logic                  rd_clk_i,
    input  logic                  rd_rst_n_i,
    fifo_burst_packer_if.master   bus,
    output logic                  busy_o,
    output logic [15:0]           burst_cnt_o
);
    localparam int WORD_W  = DATA_WIDTH * PACK_RATIO;
    localparam int NUM_GRP = BURST_LEN / PACK_RATIO;
    localparam int IDX_W   = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
    localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam logic [IDX_W-1:0]          IDX_LAST  = IDX_W'(PACK_RATIO - 1);
    localparam logic [GRP_W-1:0]          GRP_LAST  = GRP_W'(NUM_GRP - 1);
    localparam logic [FIFO_NUM_WIDTH-1:0] BURST_LVL = FIFO_NUM_WIDTH'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [IDX_W-1:0]    rd_idx_r;
    logic [GRP_W-1:0]    grp_cnt_r;
    logic [1:0]          occ_r;
    logic [1:0]          inflight_r;
    logic                cap_vld_r;
    logic [IDX_W-1:0]    cap_idx_r;
    logic                cap_last_r;
    logic [WORD_W-1:0]   pack_r;
    logic [WORD_W-1:0]   buf0_r, buf1_r;
    logic [1:0]          buf_last_r;
    logic [15:0]         burst_cnt_r;

    logic                pop_s, push_s, grp_start_s, rd_en_s;
    logic [WORD_W-1:0]   word_s;

    // Next state, group issue decision and buffer handshake.
    always_comb begin
        pop_s       = (occ_r != 2'd0) && bus.m_ready_i;
        push_s      = cap_vld_r && (cap_idx_r == IDX_LAST);
        grp_start_s = 1'b0;
        rd_en_s     = 1'b0;
        state_s     = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.fifo_num_i >= BURST_LVL) state_s = ST_READ;
                else                             state_s = ST_IDLE;
            end
            ST_READ: begin
                // A group needs a slot: 2 - occupancy - in flight + same-cycle pop > 0.
                if (rd_idx_r != {IDX_W{1'b0}}) begin
                    rd_en_s = 1'b1;
                end else if ((3'(occ_r) + 3'(inflight_r)) < (3'd2 + 3'(pop_s))) begin
                    grp_start_s = 1'b1;
                    rd_en_s     = 1'b1;
                end else begin
                    rd_en_s = 1'b0;
                end
                if (rd_en_s && (rd_idx_r == IDX_LAST) && (grp_cnt_r == GRP_LAST)) state_s = ST_DRAIN;
                else                                                               state_s = ST_READ;
            end
            ST_DRAIN: begin
                if (pop_s && buf_last_r[0]) state_s = ST_IDLE;
                else                        state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Incoming FIFO word merged into the partially packed word.
    always_comb begin
        word_s = pack_r;
        word_s[int'(cap_idx_r) * DATA_WIDTH +: DATA_WIDTH] = bus.fifo_dout_i;
    end

    // State register, read position and group accounting.
    always_ff @(posedge rd_clk_i or negedge rd_rst_n_i) begin
        if (!rd_rst_n_i) begin
            state_r    <= ST_IDLE;
            rd_idx_r   <= {IDX_W{1'b0}};
            grp_cnt_r  <= {GRP_W{1'b0}};
            inflight_r <= 2'd0;
        end else begin
            state_r <= state_s;
            if (rd_en_s) rd_idx_r <= (rd_idx_r == IDX_LAST) ? {IDX_W{1'b0}} : rd_idx_r + IDX_W'(1);
            if (state_r == ST_IDLE)                         grp_cnt_r <= {GRP_W{1'b0}};
            else if (rd_en_s && (rd_idx_r == IDX_LAST))     grp_cnt_r <= grp_cnt_r + GRP_W'(1);
            case ({grp_start_s, push_s})
                2'b10:   inflight_r <= inflight_r + 2'd1;
                2'b01:   inflight_r <= inflight_r - 2'd1;
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // FIFO data arrives one cycle after its read enable; track its slot.
    always_ff @(posedge rd_clk_i or negedge rd_rst_n_i) begin
        if (!rd_rst_n_i) begin
            cap_vld_r  <= 1'b0;
            cap_idx_r  <= {IDX_W{1'b0}};
            cap_last_r <= 1'b0;
            pack_r     <= {WORD_W{1'b0}};
        end else begin
            cap_vld_r  <= rd_en_s;
            cap_idx_r  <= rd_idx_r;
            cap_last_r <= (grp_cnt_r == GRP_LAST);
            if (cap_vld_r) pack_r <= word_s;
        end
    end

    // Two-entry in-order output buffer; entry 0 is always the head.
    always_ff @(posedge rd_clk_i or negedge rd_rst_n_i) begin
        if (!rd_rst_n_i) begin
            buf0_r     <= {WORD_W{1'b0}};
            buf1_r     <= {WORD_W{1'b0}};
            buf_last_r <= 2'b00;
            occ_r      <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        buf0_r        <= word_s;
                        buf_last_r[0] <= cap_last_r;
                    end else begin
                        buf1_r        <= word_s;
                        buf_last_r[1] <= cap_last_r;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    buf0_r        <= buf1_r;
                    buf_last_r[0] <= buf_last_r[1];
                    occ_r         <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        buf0_r        <= word_s;
                        buf_last_r[0] <= cap_last_r;
                    end else begin
                        buf0_r        <= buf1_r;
                        buf_last_r[0] <= buf_last_r[1];
                        buf1_r        <= word_s;
                        buf_last_r[1] <= cap_last_r;
                    end
                end
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Completed-burst counter, bumped when the last-flagged word leaves.
    always_ff @(posedge rd_clk_i or negedge rd_rst_n_i) begin
        if (!rd_rst_n_i)                  burst_cnt_r <= 16'd0;
        else if (pop_s && buf_last_r[0])  burst_cnt_r <= burst_cnt_r + 16'd1;
        else                              burst_cnt_r <= burst_cnt_r;
    end

    assign bus.fifo_rd_en_o = rd_en_s;
    assign bus.m_data_o     = buf0_r;
    assign bus.m_valid_o    = (occ_r != 2'd0);
    assign bus.m_last_o     = (occ_r != 2'd0) && buf_last_r[0];
    assign busy_o           = (state_r != ST_IDLE);
    assign burst_cnt_o      = burst_cnt_r;
endmodule

// File: tb/tb_fifo_burst_packer.sv
// Directed/randomized bench for fifo_burst_packer with a queue-based FIFO
// and packed-word reference model.
module tb_fifo_burst_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] burst_cnt;

    fifo_burst_packer_if #(.DATA_WIDTH(8), .PACK_RATIO(4), .FIFO_NUM_WIDTH(11)) bus ();

    fifo_burst_packer #(.DATA_WIDTH(8), .PACK_RATIO(4), .BURST_LEN(16), .FIFO_NUM_WIDTH(11)) dut (
        .rd_clk_i    (clk),
        .rd_rst_n_i  (rst_n),
        .bus         (bus),
        .busy_o      (busy),
        .burst_cnt_o (burst_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  byte_q[$];
    logic [32:0] exp_q[$];
    logic [7:0]  next_dout = 8'h00;
    int          rdy_mode = 0;
    int          cyc = 0;
    int          bursts_exp = 0;
    int          n_rd, n_words, rd_first, rd_last, val_first;
    bit          seen_valid;
    logic [31:0] first_word;
    logic        s_rd, s_valid, s_last, s_busy;
    logic [31:0] s_data;
    logic [15:0] s_cnt;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_burst(input logic [7:0] base, input bit rnd);
        logic [31:0] w;
        logic [7:0]  b;
        w = 32'h0;
        for (int i = 0; i < 16; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            byte_q.push_back(b);
            w = w | (32'(b) << (8 * (i % 4)));
            if (i % 4 == 3) begin
                exp_q.push_back({(i == 15) ? 1'b1 : 1'b0, w});
                w = 32'h0;
            end
        end
    endtask

    task automatic phase_reset();
        n_rd = 0; n_words = 0; rd_first = 0; rd_last = 0; val_first = 0;
        seen_valid = 1'b0; first_word = 32'h0;
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later, model the FIFO at the rising edge.
    task automatic cycle();
        logic [32:0] e;
        @(negedge clk);
        bus.fifo_dout_i = next_dout;
        case (rdy_mode)
            0:       bus.m_ready_i = 1'b1;
            1:       bus.m_ready_i = 1'b0;
            2:       bus.m_ready_i = (cyc % 2 == 0);
            default: bus.m_ready_i = 1'($urandom_range(0, 1));
        endcase
        bus.fifo_num_i = 11'(byte_q.size());
        #1;
        s_rd = bus.fifo_rd_en_o; s_valid = bus.m_valid_o; s_data = bus.m_data_o;
        s_last = bus.m_last_o; s_busy = busy; s_cnt = burst_cnt;
        if (s_rd) begin
            if (n_rd == 0) rd_first = cyc;
            rd_last = cyc;
            n_rd++;
            check("read_nonempty", byte_q.size() != 0, 1);
        end
        if (s_valid && !seen_valid) begin
            seen_valid = 1'b1;
            val_first = cyc;
        end
        if (prev_stall) begin
            check("stall_valid", s_valid, 1);
            check("stall_data", s_data, prev_data);
            check("stall_last", s_last, prev_last);
        end
        prev_stall = s_valid && !bus.m_ready_i;
        prev_data  = s_data;
        prev_last  = s_last;
        if (s_valid && bus.m_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("word_data", s_data, e[31:0]);
                check("word_last", s_last, e[32]);
                if (n_words == 0) first_word = s_data;
                n_words++;
                if (e[32]) bursts_exp++;
            end
        end
        @(posedge clk);
        if (s_rd && byte_q.size() != 0) next_dout = byte_q.pop_front();
        cyc++;
    endtask

    task automatic run_bursts(input int target, input int budget);
        int k;
        k = 0;
        while (bursts_exp < target && k < budget) begin
            cycle();
            k++;
        end
        check("burst_done", bursts_exp, target);
        repeat (2) cycle();
        check("busy_idle", s_busy, 0);
        check("burst_cnt", s_cnt, target);
    endtask

    initial begin
        logic [7:0] hold;
        int k;
        bus.fifo_num_i = 11'd0; bus.fifo_dout_i = 8'h00; bus.m_ready_i = 1'b1;

        // Reset state
        #12;
        check("rst_rd_en", bus.fifo_rd_en_o, 0);
        check("rst_valid", bus.m_valid_o, 0);
        check("rst_last", bus.m_last_o, 0);
        check("rst_busy", busy, 0);
        check("rst_data", bus.m_data_o, 0);
        check("rst_cnt", burst_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single burst, ready held high: contiguous reads, latency, packing
        rdy_mode = 0;
        load_burst(8'h00, 1'b0);
        phase_reset();
        run_bursts(1, 200);
        check("contig_reads", rd_last - rd_first + 1, 16);
        check("read_count", n_rd, 16);
        check("first_valid_latency", val_first - rd_first, 5);
        check("first_word_const", first_word, 32'h03020100);

        // Fill level one short of a burst never reads; reaching it reads next cycle
        load_burst(8'h40, 1'b0);
        hold = byte_q.pop_back();
        phase_reset();
        repeat (50) cycle();
        check("no_read_below_level", n_rd, 0);
        byte_q.push_back(hold);
        cycle();
        check("no_read_same_cycle", s_rd, 0);
        cycle();
        check("read_after_level", s_rd, 1);
        run_bursts(2, 200);

        // Downstream stalled from the start: two groups, then hold
        rdy_mode = 1;
        load_burst(8'h00, 1'b0);
        phase_reset();
        repeat (30) cycle();
        check("stall_read_count", n_rd, 8);
        check("stall_head_valid", s_valid, 1);
        check("stall_head_data", s_data, 32'h03020100);
        rdy_mode = 0;
        run_bursts(3, 200);
        check("stall_total_reads", n_rd, 16);
        check("stall_words", n_words, 4);

        // Ready toggling each cycle
        rdy_mode = 2;
        load_burst(8'h00, 1'b1);
        phase_reset();
        run_bursts(4, 200);
        check("toggle_words", n_words, 4);

        // Reset mid-burst after six reads
        rdy_mode = 0;
        load_burst(8'h00, 1'b1);
        phase_reset();
        k = 0;
        while (n_rd < 6 && k < 50) begin
            cycle();
            k++;
        end
        check("reads_before_reset", n_rd, 6);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", bus.fifo_rd_en_o, 0);
        check("mid_rst_valid", bus.m_valid_o, 0);
        check("mid_rst_last", bus.m_last_o, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", bus.m_data_o, 0);
        check("mid_rst_cnt", burst_cnt, 0);
        byte_q.delete();
        exp_q.delete();
        next_dout = 8'h00;
        bus.fifo_num_i = 11'd0;
        bursts_exp = 0;
        prev_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        load_burst(8'h10, 1'b0);
        phase_reset();
        run_bursts(1, 200);
        check("post_rst_first_word", first_word, 32'h13121110);

        // Two bursts back to back
        load_burst(8'h00, 1'b1);
        load_burst(8'h00, 1'b1);
        phase_reset();
        run_bursts(3, 300);
        check("two_burst_reads", n_rd, 32);
        check("two_burst_words", n_words, 8);

        // Random ready over two bursts
        rdy_mode = 3;
        load_burst(8'h00, 1'b1);
        load_burst(8'h00, 1'b1);
        phase_reset();
        run_bursts(5, 600);
        check("rand_words", n_words, 8);
        check("model_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
